// File: rtl/onchip_mem_pkg.sv
// Shared types and limits for the on-chip memory pipeline.
package onchip_mem_pkg;

    // Controller states: zero-fill after reset, then normal bus service.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit legal_read_latency(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/onchip_mem_pipe_ram.sv
// Single-port byte-enabled RAM with a registered read port.
// The array itself is never reset; only the read register is.
module onchip_mem_pipe_ram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 10,
    parameter bit    PRELOAD    = 1'b0,
    parameter string INIT_FILE  = "instr_mem.hex"
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic                    i_rd,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // A preloaded build must name its image; the image is bound to the array
    // by the implementation flow through the init-file attribute.
    if (PRELOAD && (INIT_FILE == "")) begin : g_bad_image
        $error("onchip_mem_pipe_ram: preload selected but no image file named");
    end

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register only loads on an accepted read, so it holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_en && i_rd) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/onchip_mem_pipe.sv
// Avalon-style on-chip memory slave with post-reset zero-fill and a
// 1- or 2-cycle read pipeline, all gated by a global clock enable.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | writing zero to each address in turn, bus held off
//   ST_RUN   | accepting reads and writes
module onchip_mem_pipe
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 10,
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "instr_mem.hex"
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [DATA_WIDTH/8-1:0] i_byteenable,
    input  logic                    i_chipselect,
    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [DATA_WIDTH-1:0]   i_writedata,
    input  logic                    i_clken,
    input  logic                    i_reset_req,
    output logic [DATA_WIDTH-1:0]   o_readdata,
    output logic                    o_readdatavalid,
    output logic                    o_waitrequest
);

    if (!legal_read_latency(READ_LATENCY) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_param
        $error("onchip_mem_pipe: READ_LATENCY must be 1..2 and DATA_WIDTH a multiple of 8");
    end

    mem_state_e                r_state;
    mem_state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_clr_addr;
    logic [ADDR_WIDTH-1:0]     w_clr_addr_nxt;
    logic [READ_LATENCY-1:0]   r_rd_vld;
    logic                      w_clearing;
    logic                      w_waitreq;
    logic                      w_accept;
    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic                      w_ram_we;
    logic [ADDR_WIDTH-1:0]     w_ram_addr;
    logic [DATA_WIDTH/8-1:0]   w_ram_be;
    logic [DATA_WIDTH-1:0]     w_ram_wdata;
    logic [DATA_WIDTH-1:0]     w_ram_rdata;

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_waitreq  = i_reset | w_clearing;

    // Write wins over read when both are requested in the same cycle.
    assign w_accept = i_chipselect & (i_read | i_write) & ~w_waitreq & i_clken & ~i_reset_req;
    assign w_wr_acc = w_accept & i_write;
    assign w_rd_acc = w_accept & i_read & ~i_write;

    // Clear walk: one address per enabled cycle, parks on the top address.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        if (r_state == ST_CLEAR) begin
            if (r_clr_addr == '1) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // State and clear counter; reset restarts the walk from address 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_addr <= '0;
        end else if (i_clken) begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // The clear walk borrows the single RAM port; reset itself never writes.
    assign w_ram_we    = (w_clearing & ~i_reset) | w_wr_acc;
    assign w_ram_addr  = w_clearing ? r_clr_addr : i_address;
    assign w_ram_be    = w_clearing ? '1 : i_byteenable;
    assign w_ram_wdata = w_clearing ? '0 : i_writedata;

    onchip_mem_pipe_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PRELOAD    (CLEAR_ON_RESET == 0),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_clken),
        .i_we    (w_ram_we),
        .i_rd    (w_rd_acc),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Read-valid shift chain; stalls with clken, only reset flushes it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_vld <= '0;
        end else if (i_clken) begin
            r_rd_vld[0] <= w_rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_rdata_q;
        // Extra output stage for the two-cycle read path.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_rdata_q <= '0;
            end else if (i_clken) begin
                r_rdata_q <= w_ram_rdata;
            end
        end
        assign o_readdata = r_rdata_q;
    end else begin : g_out_direct
        assign o_readdata = w_ram_rdata;
    end

    // A pending strobe is held back, not lost, while clken is low.
    assign o_readdatavalid = r_rd_vld[READ_LATENCY-1] & i_clken;
    assign o_waitrequest   = w_waitreq;

endmodule

// File: tb/tb_onchip_mem_pipe.sv
// Self-checking bench: two DUTs (read latency 1 and 2) share one stimulus
// stream and are compared against a transaction-level memory model.
module tb_onchip_mem_pipe;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          i_reset, i_chipselect, i_read, i_write, i_clken, i_reset_req;
    logic [AW-1:0] i_address;
    logic [NB-1:0] i_byteenable;
    logic [DW-1:0] i_writedata;
    logic [DW-1:0] rd1, rd2;
    logic          v1, v2, w1, w2;

    always #5 clk = ~clk;

    onchip_mem_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
        .i_clk(clk), .i_reset(i_reset), .i_address(i_address), .i_byteenable(i_byteenable),
        .i_chipselect(i_chipselect), .i_read(i_read), .i_write(i_write), .i_writedata(i_writedata),
        .i_clken(i_clken), .i_reset_req(i_reset_req),
        .o_readdata(rd1), .o_readdatavalid(v1), .o_waitrequest(w1));

    onchip_mem_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
        .i_clk(clk), .i_reset(i_reset), .i_address(i_address), .i_byteenable(i_byteenable),
        .i_chipselect(i_chipselect), .i_read(i_read), .i_write(i_write), .i_writedata(i_writedata),
        .i_clken(i_clken), .i_reset_req(i_reset_req),
        .o_readdata(rd2), .o_readdatavalid(v2), .o_waitrequest(w2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted read is a record aged by enabled clock edges; it is
    // presented when its age equals the latency and clken is high.
    typedef struct {
        int          age;
        logic [31:0] data;
    } rd_t;

    rd_t         q1[$];
    rd_t         q2[$];
    logic [31:0] mem_m [DEPTH];
    int          clear_left = DEPTH;
    bit          live = 1'b0;

    logic        last_w, last_v1, last_v2;
    logic [31:0] last_d1, last_d2;
    int          n_str1 = 0;
    int          n_str2 = 0;

    task automatic check_outputs();
        bit          ev;
        bit          ew;
        logic [31:0] ed;
        last_w  = w2;
        last_v1 = v1;
        last_v2 = v2;
        last_d1 = rd1;
        last_d2 = rd2;
        if (v1) n_str1++;
        if (v2) n_str2++;
        if (!live) return;
        ew = i_reset || (clear_left > 0);
        chk("waitrequest_l1", 32'(w1), 32'(ew));
        chk("waitrequest_l2", 32'(w2), 32'(ew));
        ev = 1'b0; ed = '0;
        foreach (q1[i]) if (q1[i].age == 1) begin ev = 1'b1; ed = q1[i].data; end
        ev = ev && i_clken;
        chk("rdvalid_l1", 32'(v1), 32'(ev));
        if (ev) chk("rddata_l1", rd1, ed);
        ev = 1'b0; ed = '0;
        foreach (q2[i]) if (q2[i].age == 2) begin ev = 1'b1; ed = q2[i].data; end
        ev = ev && i_clken;
        chk("rdvalid_l2", 32'(v2), 32'(ev));
        if (ev) chk("rddata_l2", rd2, ed);
    endtask

    task automatic model_edge();
        if (i_reset) begin
            live = 1'b1;
            q1.delete();
            q2.delete();
            clear_left = DEPTH;
            return;
        end
        if (!live || !i_clken) return;
        foreach (q1[i]) q1[i].age++;
        foreach (q2[i]) q2[i].age++;
        while (q1.size() > 0 && q1[0].age > 1) void'(q1.pop_front());
        while (q2.size() > 0 && q2[0].age > 2) void'(q2.pop_front());
        if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
        end else if (i_chipselect && (i_read || i_write) && !i_reset_req) begin
            if (i_write) begin
                for (int b = 0; b < NB; b++)
                    if (i_byteenable[b]) mem_m[i_address][b*8 +: 8] = i_writedata[b*8 +: 8];
            end else begin
                q1.push_back('{1, mem_m[i_address]});
                q2.push_back('{1, mem_m[i_address]});
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        i_chipselect = 1'b0;
        i_read       = 1'b0;
        i_write      = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [NB-1:0] be);
        i_chipselect = 1'b1; i_write = 1'b1; i_read = 1'b0;
        i_address = a; i_writedata = d; i_byteenable = be;
        step();
        idle();
    endtask

    task automatic rdreq(input logic [AW-1:0] a);
        i_chipselect = 1'b1; i_read = 1'b1; i_write = 1'b0; i_address = a;
        step();
        idle();
    endtask

    task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        bit got = 1'b0;
        rdreq(a);
        for (int k = 0; k < 6 && !got; k++) begin
            step();
            if (last_v2) begin
                got = 1'b1;
                chk(tag, last_d2, exp);
            end
        end
        chk("read_strobe_seen", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        step();
        chk("reset_rdata_l1", last_d1, 32'h0);
        chk("reset_rdata_l2", last_d2, 32'h0);
        chk("reset_rdvalid_l2", 32'(last_v2), 32'd0);
        chk("reset_waitreq", 32'(last_w), 32'd1);
    endtask

    task automatic count_clear(input string tag);
        int n = 0;
        i_reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!last_w) break;
            n++;
        end
        chk(tag, n, 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s1, s2, idx1, idx2;
        logic [6:0]  seq;
        logic [31:0] dq[$];

        i_reset = 1'b1; i_clken = 1'b1; i_reset_req = 1'b0;
        idle();
        i_address = '0; i_byteenable = '1; i_writedata = '0;

        do_reset();
        count_clear("clear_len_initial");

        // Every location reads zero after the fill, back to back.
        s1 = n_str1; s2 = n_str2;
        for (int a = 0; a < DEPTH; a++) begin
            i_chipselect = 1'b1; i_read = 1'b1; i_address = AW'(a);
            step();
        end
        idle();
        repeat (4) step();
        chk("zero_reads_cnt_l1", n_str1 - s1, 32'd16);
        chk("zero_reads_cnt_l2", n_str2 - s2, 32'd16);

        // Byte-lane merge.
        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h00001100, 4'b0010);
        read_expect("be_merge", 4'd3, 32'hAABB11DD);

        // Three consecutive reads through the two-cycle path.
        wr(4'd1, 32'h11111111, 4'hF);
        wr(4'd2, 32'h22222222, 4'hF);
        wr(4'd3, 32'h33333333, 4'hF);
        seq = '0;
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                i_chipselect = 1'b1; i_read = 1'b1; i_address = AW'(k + 1);
            end else begin
                idle();
            end
            step();
            seq[k] = last_v2;
            if (last_v2) dq.push_back(last_d2);
        end
        chk("b2b_pattern", 32'(seq), 32'h1C);
        chk("b2b_count", dq.size(), 32'd3);
        if (dq.size() == 3) begin
            chk("b2b_data0", dq[0], 32'h11111111);
            chk("b2b_data1", dq[1], 32'h22222222);
            chk("b2b_data2", dq[2], 32'h33333333);
        end

        // clken low for three cycles with a read outstanding.
        wr(4'd7, 32'hCAFEF00D, 4'hF);
        idx1 = -1; idx2 = -1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                i_chipselect = 1'b1; i_read = 1'b1; i_address = 4'd7;
            end else begin
                idle();
            end
            i_clken = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
            step();
            if (last_v1 && idx1 < 0) begin idx1 = k; chk("stall_data_l1", last_d1, 32'hCAFEF00D); end
            if (last_v2 && idx2 < 0) begin idx2 = k; chk("stall_data_l2", last_d2, 32'hCAFEF00D); end
        end
        i_clken = 1'b1;
        chk("stall_strobe_idx_l1", idx1, 32'd4);
        chk("stall_strobe_idx_l2", idx2, 32'd5);

        // read+write together: write only, no strobe.
        s1 = n_str1; s2 = n_str2;
        i_chipselect = 1'b1; i_read = 1'b1; i_write = 1'b1;
        i_address = 4'd5; i_writedata = 32'h12345678; i_byteenable = 4'hF;
        step();
        idle();
        repeat (4) step();
        chk("rdwr_no_strobe_l1", n_str1 - s1, 32'd0);
        chk("rdwr_no_strobe_l2", n_str2 - s2, 32'd0);
        read_expect("rdwr_then_read", 4'd5, 32'h12345678);

        // Read in the cycle right after a write.
        wr(4'd9, 32'h0BADBEEF, 4'hF);
        read_expect("read_after_write", 4'd9, 32'h0BADBEEF);

        // reset_req blocks new requests but lets the in-flight read finish.
        s2 = n_str2;
        rdreq(4'd2);
        i_reset_req = 1'b1;
        i_chipselect = 1'b1; i_read = 1'b1; i_address = 4'd3;
        step();
        step();
        i_reset_req = 1'b0;
        idle();
        repeat (4) step();
        chk("reset_req_strobes", n_str2 - s2, 32'd1);

        // Reset with a read in flight drops it.
        wr(4'd12, 32'h5A5A5A5A, 4'hF);
        s2 = n_str2;
        rdreq(4'd12);
        do_reset();
        count_clear("clear_len_after_midread");
        chk("midread_dropped_l2", n_str2 - s2, 32'd0);

        // Reset at clear counter 7 restarts the whole fill.
        wr(4'd10, 32'hDEADBEEF, 4'hF);
        wr(4'd14, 32'hFEEDFACE, 4'hF);
        do_reset();
        i_reset = 1'b0;
        repeat (7) step();
        i_reset = 1'b1;
        step();
        count_clear("clear_restart_len");
        read_expect("cleared_addr10", 4'd10, 32'h0);
        read_expect("cleared_addr14", 4'd14, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            i_chipselect = ($urandom_range(0, 3) != 0);
            i_read       = $urandom_range(0, 1);
            i_write      = ($urandom_range(0, 2) == 0);
            i_address    = AW'($urandom_range(0, DEPTH - 1));
            i_byteenable = NB'($urandom);
            i_writedata  = $urandom;
            i_clken      = ($urandom_range(0, 7) != 0);
            i_reset_req  = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        i_clken = 1'b1;
        i_reset_req = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
